lsu_rmw: RTL and testbench

- Load/store unit between the core's memory-access stage and data_mem. It is the direct upstream driver of data_mem's clk/addr/write_data/WE/read_data port set.
- Converts RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide data_mem accesses.
- Handles loads with sign or zero extension.
- Implements sub-word stores as read-modify-write, because data_mem has no byte enables.
- Stalls the core while a multi-cycle access is in flight.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_extract.sv | 27 ++
 rtl/lsu_rmw.sv | 132 +++++++++++++
 tb/tb_lsu_rmw.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM encoding and
// request legality helpers.
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_LOAD_WAIT = 2'd1;
  localparam state_t ST_RMW_WAIT  = 2'd2;
  localparam state_t ST_RMW_WRITE = 2'd3;

  // Unsigned sizes only exist for loads.
  function automatic logic is_illegal_size(logic [2:0] size, logic we);
    case (size)
      SZ_B, SZ_H, SZ_W: is_illegal_size = 1'b0;
      SZ_BU, SZ_HU:     is_illegal_size = we;
      default:          is_illegal_size = 1'b1;
    endcase
  endfunction

  function automatic logic is_misaligned(logic [2:0] size, logic [1:0] off);
    case (size)
      SZ_H, SZ_HU: is_misaligned = off[0];
      SZ_W:        is_misaligned = (off != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// Load lane select with sign/zero extension of a 32-bit memory word.
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] result_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign byte_c = word[{off, 3'b000} +: 8];
  assign half_c = word[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (size)
      SZ_B:    result_c = {{24{byte_c[7]}}, byte_c};
      SZ_BU:   result_c = {24'h000000, byte_c};
      SZ_H:    result_c = {{16{half_c[15]}}, half_c};
      SZ_HU:   result_c = {16'h0000, half_c};
      default: result_c = word;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// RV32 load/store unit driving a word-wide data_mem without byte enables;
// sub-word stores are read-modify-write. Optional counters: LSU_STATS_EN.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rd_i
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]       stat_loads_o,
  output logic [31:0]       stat_stores_o,
  output logic [31:0]       stat_rmw_o,
  output logic [31:0]       stat_err_o
`endif
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] merge_q, merge_d, merged_c, load_c;
  logic [DATA_W-1:0] rd_c, wd_c;
  logic [1:0]        off;
  logic              bad_c, stall_c, err_c, we_c, sw_c;

  assign off   = core_addr_i[1:0];
  assign bad_c = is_illegal_size(core_size_i, core_we_i) | is_misaligned(core_size_i, off);

  lsu_extract u_extract (
    .word     (mem_rd_i),
    .off      (off),
    .size     (core_size_i),
    .result_c (load_c)
  );

  // Old word with the addressed lane replaced by the store data.
  always_comb begin
    merged_c = mem_rd_i;
    if (core_size_i == SZ_B) merged_c[{off, 3'b000} +: 8] = core_wd_i[7:0];
    else                     merged_c[{off[1], 4'b0000} +: 16] = core_wd_i[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

  // Next state and the combinational core/memory handshake.
  always_comb begin
    state_d = state_q;
    merge_d = merge_q;
    stall_c = 1'b0;
    err_c   = 1'b0;
    we_c    = 1'b0;
    sw_c    = 1'b0;
    wd_c    = '0;
    rd_c    = '0;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i) begin
          if (bad_c) begin
            err_c = 1'b1;
          end else if (core_we_i && core_size_i == SZ_W) begin
            sw_c = 1'b1;
            we_c = 1'b1;
            wd_c = core_wd_i;
          end else begin
            stall_c = 1'b1;
            state_d = core_we_i ? ST_RMW_WAIT : ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        rd_c    = load_c;
        state_d = ST_IDLE;
      end
      ST_RMW_WAIT: begin
        merge_d = merged_c;
        stall_c = 1'b1;
        state_d = ST_RMW_WRITE;
      end
      ST_RMW_WRITE: begin
        we_c    = 1'b1;
        wd_c    = merge_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything is held at zero while reset is asserted.
  assign core_rd_o    = rst_n ? rd_c : '0;
  assign core_stall_o = rst_n & stall_c;
  assign core_err_o   = rst_n & err_c;
  assign mem_we_o     = rst_n & we_c;
  assign mem_wd_o     = rst_n ? wd_c : '0;
  assign mem_addr_o   = rst_n ? {core_addr_i[ADDR_W-1:2], 2'b00} : '0;

`ifdef LSU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads_o  <= '0;
      stat_stores_o <= '0;
      stat_rmw_o    <= '0;
      stat_err_o    <= '0;
    end else begin
      if (state_q == ST_LOAD_WAIT)         stat_loads_o  <= stat_loads_o + 32'd1;
      if (sw_c || state_q == ST_RMW_WRITE) stat_stores_o <= stat_stores_o + 32'd1;
      if (state_q == ST_RMW_WRITE)         stat_rmw_o    <= stat_rmw_o + 32'd1;
      if (err_c)                           stat_err_o    <= stat_err_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw with a synchronous-read data_mem model and a
// word-array reference model of RV32 load/store semantics.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        core_stall, core_err;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;
`ifdef LSU_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_rmw, stat_err;
`endif

  logic [31:0] dmem    [0:63];
  logic [31:0] ref_mem [0:63];
  logic        mem_init;
  logic        watch_we;
  int          we_hits;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  lsu_rmw dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .core_err_o   (core_err),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_we_o     (mem_we),
    .mem_rd_i     (mem_rd)
`ifdef LSU_STATS_EN
    ,
    .stat_loads_o  (stat_loads),
    .stat_stores_o (stat_stores),
    .stat_rmw_o    (stat_rmw),
    .stat_err_o    (stat_err)
`endif
  );

  function automatic logic [31:0] init_word(int i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  // data_mem: synchronous read, write on rising edge when WE is high.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
    end else begin
      if (mem_we) dmem[mem_addr[7:2]] <= mem_wd;
      mem_rd <= dmem[mem_addr[7:2]];
    end
  end

  always @(posedge clk) if (watch_we && mem_we) we_hits <= we_hits + 1;

  // Reference model: legality, load value and merged store word.
  function automatic logic ref_legal(logic we, logic [2:0] sz, logic [31:0] a);
    if (!(sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5)) return 1'b0;
    if (we && sz >= 4) return 1'b0;
    if ((sz == 1 || sz == 5) && (a % 2 != 0)) return 1'b0;
    if (sz == 2 && (a % 4 != 0)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] sz, logic [31:0] a);
    logic [31:0] v;
    case (sz)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (sz == 0 && v >= 128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w >> (8 * (a % 4))) & 32'hFFFF;
        if (sz == 1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w, logic [2:0] sz, logic [31:0] a,
                                            logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    if (sz == 2) return d;
    sh   = 8 * int'(a % 4);
    mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic int ref_cycles(logic we, logic [2:0] sz, logic [31:0] a);
    if (!ref_legal(we, sz, a)) return 1;
    if (!we) return 2;
    return (sz == 2) ? 1 : 3;
  endfunction

  // Drive one request at a falling edge and observe it until stall drops.
  task automatic run_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int cyc, output int wes,
                        output logic [31:0] wd_seen, output logic err_seen,
                        output logic [31:0] rd_seen, output logic addr_ok);
    logic done = 1'b0;
    core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = d;
    cyc = 0; wes = 0; wd_seen = '0; err_seen = 1'b0; rd_seen = '0; addr_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      cyc++;
      if (mem_we) begin wes++; wd_seen = mem_wd; end
      if (core_err) err_seen = 1'b1;
      if (mem_addr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      if (!core_stall) begin rd_seen = core_rd; done = 1'b1; break; end
      @(negedge clk);
    end
    if (!done) cyc = 99;
    @(negedge clk);
  endtask

  task automatic idle_bus();
    core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = '0; core_wd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h44; core_wd = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({core_rd, core_stall, core_err, mem_addr, mem_wd, mem_we} !== '0)
      $display("FAIL reset_outputs rd=%h stall=%b err=%b addr=%h wd=%h we=%b required all 0",
               core_rd, core_stall, core_err, mem_addr, mem_wd, mem_we);
    else n_pass++;
    idle_bus();
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sw_lw();
    int cyc, wes; logic [31:0] wd, rd; logic err, aok;
    run_op(1'b1, 3'd2, 32'h10, 32'h11223344, cyc, wes, wd, err, rd, aok);
    ref_mem[4] = 32'h11223344;
    n_checks++;
    if (cyc !== 1 || wes !== 1 || wd !== 32'h11223344 || err !== 1'b0)
      $display("FAIL sw cyc=%0d we=%0d wd=%h err=%b required 1 1 11223344 0", cyc, wes, wd, err);
    else n_pass++;
    run_op(1'b0, 3'd2, 32'h10, 32'h0, cyc, wes, wd, err, rd, aok);
    n_checks++;
    if (cyc !== 2 || wes !== 0 || rd !== 32'h11223344 || !aok)
      $display("FAIL lw cyc=%0d we=%0d rd=%h aok=%b required 2 0 11223344 1", cyc, wes, rd, aok);
    else n_pass++;
  endtask

  task automatic test_load_ext();
    int cyc, wes; logic [31:0] wd, rd; logic err, aok;
    logic [2:0]  sz  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ad  [4] = '{32'h23, 32'h23, 32'h22, 32'h20};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    run_op(1'b1, 3'd2, 32'h20, 32'h80FF7F01, cyc, wes, wd, err, rd, aok);
    ref_mem[8] = 32'h80FF7F01;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, sz[i], ad[i], 32'h0, cyc, wes, wd, err, rd, aok);
      n_checks++;
      if (cyc !== 2 || rd !== exp[i] || wes !== 0)
        $display("FAIL load_ext[%0d] cyc=%0d rd=%h we=%0d required 2 %h 0", i, cyc, rd, wes, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_subword_store();
    int cyc, wes; logic [31:0] wd, rd; logic err, aok;
    run_op(1'b1, 3'd2, 32'h30, 32'h11223344, cyc, wes, wd, err, rd, aok);
    ref_mem[12] = 32'h11223344;
    run_op(1'b1, 3'd1, 32'h32, 32'h0000BEEF, cyc, wes, wd, err, rd, aok);
    ref_mem[12] = 32'hBEEF3344;
    n_checks++;
    if (cyc !== 3 || wes !== 1 || wd !== 32'hBEEF3344 || rd !== 32'h0)
      $display("FAIL sh cyc=%0d we=%0d wd=%h rd=%h required 3 1 beef3344 0", cyc, wes, wd, rd);
    else n_pass++;
    run_op(1'b1, 3'd0, 32'h31, 32'h000000AA, cyc, wes, wd, err, rd, aok);
    ref_mem[12] = 32'hBEEFAA44;
    n_checks++;
    if (cyc !== 3 || wes !== 1 || wd !== 32'hBEEFAA44)
      $display("FAIL sb cyc=%0d we=%0d wd=%h required 3 1 beefaa44", cyc, wes, wd);
    else n_pass++;
  endtask

  task automatic test_errors();
    int cyc, wes; logic [31:0] wd, rd; logic err, aok;
    logic        we [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  sz [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] ad [3] = '{32'h06, 32'h01, 32'h08};
    for (int i = 0; i < 3; i++) begin
      run_op(we[i], sz[i], ad[i], 32'hDEADBEEF, cyc, wes, wd, err, rd, aok);
      n_checks++;
      if (cyc !== 1 || wes !== 0 || err !== 1'b1)
        $display("FAIL err[%0d] cyc=%0d we=%0d err=%b required 1 0 1", i, cyc, wes, err);
      else n_pass++;
    end
    idle_bus();
    #1;
    n_checks++;
    if (core_err !== 1'b0 || core_stall !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL err_pulse err=%b stall=%b we=%b required 0 0 0", core_err, core_stall, mem_we);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int cyc, wes; logic [31:0] wd, rd; logic err, aok;
    run_op(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, cyc, wes, wd, err, rd, aok);
    ref_mem[16] = 32'hCAFEF00D;
    we_hits = 0; watch_we = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_size = 3'd0; core_addr = 32'h40; core_wd = 32'h55;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({core_rd, core_stall, core_err, mem_addr, mem_wd, mem_we} !== '0)
      $display("FAIL midop_reset_outputs stall=%b we=%b addr=%h wd=%h required all 0",
               core_stall, mem_we, mem_addr, mem_wd);
    else n_pass++;
    repeat (2) @(negedge clk);
    idle_bus();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    watch_we = 1'b0;
    n_checks++;
    if (we_hits !== 0) $display("FAIL midop_no_write we_hits=%0d required 0", we_hits);
    else n_pass++;
    run_op(1'b0, 3'd2, 32'h40, 32'h0, cyc, wes, wd, err, rd, aok);
    n_checks++;
    if (cyc !== 2 || rd !== 32'hCAFEF00D)
      $display("FAIL midop_after cyc=%0d rd=%h required 2 cafef00d", cyc, rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, wes, tot; logic [31:0] wd, rd; logic err, aok;
    time t0;
    do_reset();
    t0 = $time;
    run_op(1'b1, 3'd2, 32'h50, 32'h8899AABB, cyc, wes, wd, err, rd, aok);
    ref_mem[20] = 32'h8899AABB;
    run_op(1'b0, 3'd0, 32'h52, 32'h0, cyc, wes, wd, err, rd, aok);
    n_checks++;
    if (rd !== ref_load(ref_mem[20], 3'd0, 32'h52))
      $display("FAIL b2b_lb rd=%h required %h", rd, ref_load(ref_mem[20], 3'd0, 32'h52));
    else n_pass++;
    run_op(1'b1, 3'd1, 32'h50, 32'h00001234, cyc, wes, wd, err, rd, aok);
    ref_mem[20] = ref_store(ref_mem[20], 3'd1, 32'h50, 32'h00001234);
    run_op(1'b0, 3'd2, 32'h50, 32'h0, cyc, wes, wd, err, rd, aok);
    tot = int'(($time - t0) / 10);
    n_checks++;
    if (tot !== 8 || rd !== ref_mem[20])
      $display("FAIL b2b total=%0d rd=%h required 8 %h", tot, rd, ref_mem[20]);
    else n_pass++;
`ifdef LSU_STATS_EN
    n_checks++;
    if (stat_loads !== 2 || stat_stores !== 2 || stat_rmw !== 1 || stat_err !== 0)
      $display("FAIL stats loads=%0d stores=%0d rmw=%0d err=%0d required 2 2 1 0",
               stat_loads, stat_stores, stat_rmw, stat_err);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int cyc, wes, ecyc; logic [31:0] wd, rd, a, d, w, ew; logic err, aok, we, legal;
    logic [2:0] sz;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      d  = $urandom;
      w  = ref_mem[a[7:2]];
      legal = ref_legal(we, sz, a);
      ecyc  = ref_cycles(we, sz, a);
      ew    = ref_store(w, sz, a, d);
      run_op(we, sz, a, d, cyc, wes, wd, err, rd, aok);
      n_checks++;
      if (cyc !== ecyc || err !== !legal || wes !== ((legal && we) ? 1 : 0) || !aok)
        $display("FAIL rand[%0d] we=%b sz=%0d a=%h cyc=%0d err=%b wes=%0d aok=%b required %0d %b %0d 1",
                 i, we, sz, a, cyc, err, wes, aok, ecyc, !legal, (legal && we) ? 1 : 0);
      else n_pass++;
      if (legal && we) begin
        n_checks++;
        if (wd !== ew) $display("FAIL rand_store[%0d] wd=%h required %h", i, wd, ew);
        else n_pass++;
        ref_mem[a[7:2]] = ew;
      end else begin
        n_checks++;
        if (rd !== ((legal && !we) ? ref_load(w, sz, a) : 32'h0))
          $display("FAIL rand_load[%0d] rd=%h required %h", i, rd,
                   (legal && !we) ? ref_load(w, sz, a) : 32'h0);
        else n_pass++;
      end
    end
    idle_bus();
    @(negedge clk);
  endtask

  task automatic test_mem_image();
    int bad = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL mem_image mismatched_words=%0d required 0", bad);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    mem_init = 1'b1;
    watch_we = 1'b0;
    we_hits  = 0;
    @(negedge clk);
    test_reset();
    test_sw_lw();
    test_load_ext();
    test_subword_store();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    test_random();
    test_mem_image();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
